generador_onda_cuadrada: RTL and testbench

//   Programmable square-wave generator, the stimulus source for the period meter.

---
 rtl/generador_onda_cuadrada_pkg.sv | 15 +
 rtl/generador_onda_cuadrada_divisor_us.sv | 39 +++
 rtl/generador_onda_cuadrada.sv | 125 ++++++++++++
 tb/tb_generador_onda_cuadrada.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/generador_onda_cuadrada_pkg.sv
// ---------------------------------------------------------------------------
// generador_onda_cuadrada_pkg
//   Defaults and state encoding shared by the square-wave generator files.
// ---------------------------------------------------------------------------
package generador_onda_cuadrada_pkg;

   localparam int CANT_BITS_DEF     = 12;  // period / high-time field width (us)
   localparam int CICLOS_POR_US_DEF = 50;  // 50 MHz board clock

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } estado_t;

endpackage

// File: rtl/generador_onda_cuadrada_divisor_us.sv
// ---------------------------------------------------------------------------
// divisor_us
//   Prescaler that derives a 1 us tick from reloj_FPGA.
//   Ports:
//     reloj_FPGA  in   clock, rising edge
//     reset       in   synchronous, active-high
//     habilitar   in   1 = count; 0 = hold the counter at 0
//     tick_us     out  1 in the cycle the counter wraps (combinational)
// ---------------------------------------------------------------------------
module divisor_us
   import generador_onda_cuadrada_pkg::*;
#(
   parameter int CICLOS_POR_US = CICLOS_POR_US_DEF
) (
   input  logic reloj_FPGA,
   input  logic reset,
   input  logic habilitar,
   output logic tick_us
);

   // A 1-cycle microsecond still needs a 1-bit counter to stay legal.
   localparam int               ANCHO  = (CICLOS_POR_US > 1) ? $clog2(CICLOS_POR_US) : 1;
   localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(CICLOS_POR_US - 1);
   localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);

   logic [ANCHO-1:0] cnt;

   always_ff @(posedge reloj_FPGA) begin
      if (reset || !habilitar)
         cnt <= '0;
      else if (cnt == ULTIMO)
         cnt <= '0;
      else
         cnt <= cnt + UNO;
   end

   assign tick_us = habilitar && (cnt == ULTIMO);

endmodule

// File: rtl/generador_onda_cuadrada.sv
// ---------------------------------------------------------------------------
// generador_onda_cuadrada
//   Programmable square-wave generator. Period and high time are given in
//   microseconds; new settings are double-buffered and only take effect on a
//   period boundary (or immediately while idle / disabled).
//   Ports:
//     reloj_FPGA       in   clock, rising edge
//     reset            in   synchronous, active-high
//     habilitar        in   1 = generate, 0 = stop with output low
//     cargar           in   1-cycle strobe capturing periodo_us / alto_us
//     periodo_us       in   requested period (us), < 2 is invalid
//     alto_us          in   requested high time (us)
//     onda_cuadrada    out  generated wave (registered)
//     flanco_pos       out  pulse in the cycle onda_cuadrada rises
//     config_aplicada  out  pulse when a new config becomes active
//     pendiente        out  a captured config waits for the next boundary
// ---------------------------------------------------------------------------
module generador_onda_cuadrada
   import generador_onda_cuadrada_pkg::*;
#(
   parameter int CANT_BITS     = CANT_BITS_DEF,
   parameter int CICLOS_POR_US = CICLOS_POR_US_DEF
) (
   input  logic                 reloj_FPGA,
   input  logic                 reset,
   input  logic                 habilitar,
   input  logic                 cargar,
   input  logic [CANT_BITS-1:0] periodo_us,
   input  logic [CANT_BITS-1:0] alto_us,
   output logic                 onda_cuadrada,
   output logic                 flanco_pos,
   output logic                 config_aplicada,
   output logic                 pendiente
);

   localparam logic [CANT_BITS-1:0] UNO = CANT_BITS'(1);

   estado_t              estado;
   logic [CANT_BITS-1:0] per_act, alto_act, per_pend, alto_pend;
   logic [CANT_BITS-1:0] cnt_us;
   logic                 tick_us;

   logic                 fin_periodo, ventana, aplicar, valida_sig, alto_nxt;
   logic [CANT_BITS-1:0] per_sig, alto_sig, cnt_sig;

   divisor_us #(.CICLOS_POR_US(CICLOS_POR_US)) u_divisor_us (
      .reloj_FPGA (reloj_FPGA),
      .reset      (reset),
      .habilitar  ((estado == RUN) && habilitar),
      .tick_us    (tick_us)
   );

   always_comb begin
      fin_periodo = (estado == RUN) && tick_us && (cnt_us == per_act - UNO);
      // Points where a swap of the active config cannot glitch the output.
      ventana     = fin_periodo || (estado == IDLE) || !habilitar;
      aplicar     = ventana && (pendiente || cargar);
      per_sig     = per_act;
      alto_sig    = alto_act;
      if (aplicar) begin
         // A strobe landing on the boundary skips the pending regs.
         per_sig  = cargar ? periodo_us : per_pend;
         alto_sig = cargar ? alto_us    : alto_pend;
      end
      valida_sig  = (per_sig > UNO);
      cnt_sig     = cnt_us;
      if (tick_us)
         cnt_sig = fin_periodo ? '0 : cnt_us + UNO;
      // alto >= periodo naturally gives a constant-high wave here.
      alto_nxt    = (cnt_sig < alto_sig);
   end

   always_ff @(posedge reloj_FPGA) begin
      if (reset) begin
         estado          <= IDLE;
         per_act         <= '0;
         alto_act        <= '0;
         per_pend        <= '0;
         alto_pend       <= '0;
         cnt_us          <= '0;
         onda_cuadrada   <= 1'b0;
         flanco_pos      <= 1'b0;
         config_aplicada <= 1'b0;
         pendiente       <= 1'b0;
      end else begin
         per_act         <= per_sig;
         alto_act        <= alto_sig;
         config_aplicada <= aplicar;

         if (cargar && !ventana) begin
            per_pend  <= periodo_us;
            alto_pend <= alto_us;
            pendiente <= 1'b1;
         end else if (aplicar) begin
            pendiente <= 1'b0;
         end

         flanco_pos <= 1'b0;
         case (estado)
            IDLE: begin
               cnt_us        <= '0;
               onda_cuadrada <= 1'b0;
               if (habilitar && valida_sig) begin
                  estado        <= RUN;
                  onda_cuadrada <= (alto_sig != '0);
                  flanco_pos    <= (alto_sig != '0);
               end
            end
            RUN: begin
               if (!habilitar || !valida_sig) begin
                  estado        <= IDLE;
                  cnt_us        <= '0;
                  onda_cuadrada <= 1'b0;
               end else begin
                  cnt_us        <= cnt_sig;
                  onda_cuadrada <= alto_nxt;
                  flanco_pos    <= alto_nxt && !onda_cuadrada;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_generador_onda_cuadrada.sv
module tb_generador_onda_cuadrada;

   localparam int CB = 12;
   localparam int N  = 2;

   logic          reloj_FPGA = 1'b0;
   logic          reset = 1'b1;
   logic          habilitar = 1'b0;
   logic          cargar = 1'b0;
   logic [CB-1:0] periodo_us = '0;
   logic [CB-1:0] alto_us = '0;
   logic          onda_cuadrada, flanco_pos, config_aplicada, pendiente;

   int n_total = 0;
   int n_pass  = 0;

   generador_onda_cuadrada #(.CANT_BITS(CB), .CICLOS_POR_US(N)) dut (
      .reloj_FPGA      (reloj_FPGA),
      .reset           (reset),
      .habilitar       (habilitar),
      .cargar          (cargar),
      .periodo_us      (periodo_us),
      .alto_us         (alto_us),
      .onda_cuadrada   (onda_cuadrada),
      .flanco_pos      (flanco_pos),
      .config_aplicada (config_aplicada),
      .pendiente       (pendiente)
   );

   always #5 reloj_FPGA = ~reloj_FPGA;

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic paso();
      @(posedge reloj_FPGA);
      #1;
   endtask

   // Expected {onda, flanco} for cycle k after the wave (re)started,
   // for 0 < alto < per.
   function automatic logic [1:0] patron(int k, int per, int alto);
      int ph;
      ph = k % (per * N);
      return {ph < alto * N, ph == 0};
   endfunction

   task automatic hacer_reset();
      reset = 1'b1; cargar = 1'b0; habilitar = 1'b1;
      periodo_us = '0; alto_us = '0;
      repeat (3) paso();
      reset = 1'b0;
   endtask

   // Strobe a config; returns just after the capturing edge (cycle k=0).
   task automatic cargar_cfg(int per, int alto);
      periodo_us = CB'(per); alto_us = CB'(alto); cargar = 1'b1;
      paso();
      cargar = 1'b0;
   endtask

   task automatic test_reset();
      hacer_reset();
      for (int k = 0; k < 20; k++) begin
         n_total++;
         if ({onda_cuadrada, flanco_pos, config_aplicada, pendiente} !== 4'b0000)
            $display("FAIL reset k=%0d got onda/flanco/aplic/pend=%b%b%b%b want 0000",
                     k, onda_cuadrada, flanco_pos, config_aplicada, pendiente);
         else n_pass++;
         paso();
      end
   endtask

   task automatic test_basico();
      hacer_reset();
      cargar_cfg(5, 3);
      n_total++;
      if ({config_aplicada, pendiente} !== 2'b10)
         $display("FAIL basico_aplic got aplic/pend=%b%b want 10", config_aplicada, pendiente);
      else n_pass++;
      for (int k = 0; k < 30; k++) begin
         n_total++;
         if ({onda_cuadrada, flanco_pos} !== patron(k, 5, 3))
            $display("FAIL basico k=%0d got %b%b want %b", k, onda_cuadrada, flanco_pos, patron(k, 5, 3));
         else n_pass++;
         paso();
      end
   endtask

   task automatic test_doble_buffer();
      logic [1:0] esp;
      hacer_reset();
      cargar_cfg(5, 3);
      for (int k = 0; k < 34; k++) begin
         esp = (k < 10) ? patron(k, 5, 3) : patron(k - 10, 4, 1);
         n_total++;
         if ({onda_cuadrada, flanco_pos} !== esp)
            $display("FAIL doble_buffer k=%0d got %b%b want %b", k, onda_cuadrada, flanco_pos, esp);
         else n_pass++;
         if (k == 3 || k == 9 || k == 10) begin
            n_total++;
            if ({config_aplicada, pendiente} !== ((k == 10) ? 2'b10 : 2'b01))
               $display("FAIL doble_buffer_flags k=%0d got aplic/pend=%b%b", k, config_aplicada, pendiente);
            else n_pass++;
         end
         if (k == 2) begin periodo_us = 4; alto_us = 1; cargar = 1'b1; end
         else cargar = 1'b0;
         paso();
      end
   endtask

   task automatic test_invalida();
      logic [1:0] esp;
      hacer_reset();
      cargar_cfg(5, 3);
      for (int k = 0; k < 30; k++) begin
         esp = (k < 10) ? patron(k, 5, 3) : 2'b00;
         n_total++;
         if ({onda_cuadrada, flanco_pos} !== esp)
            $display("FAIL invalida k=%0d got %b%b want %b", k, onda_cuadrada, flanco_pos, esp);
         else n_pass++;
         if (k == 10) begin
            n_total++;
            if ({config_aplicada, pendiente} !== 2'b10)
               $display("FAIL invalida_aplic got aplic/pend=%b%b want 10", config_aplicada, pendiente);
            else n_pass++;
         end
         if (k == 2) begin periodo_us = 1; alto_us = 3; cargar = 1'b1; end
         else cargar = 1'b0;
         paso();
      end
   endtask

   task automatic test_clamps();
      int flancos;
      logic [1:0] esp;
      flancos = 0;
      hacer_reset();
      cargar_cfg(5, 0);
      for (int k = 0; k < 50; k++) begin
         esp = (k < 30) ? 2'b00 : ((k == 30) ? 2'b11 : 2'b10);
         n_total++;
         if ({onda_cuadrada, flanco_pos} !== esp)
            $display("FAIL clamps k=%0d got %b%b want %b", k, onda_cuadrada, flanco_pos, esp);
         else n_pass++;
         if (flanco_pos === 1'b1) flancos++;
         if (k == 24) begin
            n_total++;
            if (pendiente !== 1'b1)
               $display("FAIL clamps_pend got %b want 1", pendiente);
            else n_pass++;
         end
         if (k == 23) begin periodo_us = 5; alto_us = 7; cargar = 1'b1; end
         else cargar = 1'b0;
         paso();
      end
      n_total++;
      if (flancos != 1)
         $display("FAIL clamps_cuenta_flancos got %0d want 1", flancos);
      else n_pass++;
   endtask

   task automatic test_habilitar();
      logic [1:0] esp;
      hacer_reset();
      cargar_cfg(5, 3);
      for (int k = 0; k < 33; k++) begin
         if (k < 8)       esp = patron(k, 5, 3);
         else if (k < 13) esp = 2'b00;
         else             esp = patron(k - 13, 5, 3);
         n_total++;
         if ({onda_cuadrada, flanco_pos} !== esp)
            $display("FAIL habilitar k=%0d got %b%b want %b", k, onda_cuadrada, flanco_pos, esp);
         else n_pass++;
         if (k == 7)  habilitar = 1'b0;
         if (k == 12) habilitar = 1'b1;
         paso();
      end
   endtask

   task automatic test_reset_en_marcha();
      hacer_reset();
      cargar_cfg(5, 3);
      paso(); paso();
      cargar_cfg(4, 1);
      n_total++;
      if ({onda_cuadrada, pendiente} !== 2'b11)
         $display("FAIL reset_marcha_pre got onda/pend=%b%b want 11", onda_cuadrada, pendiente);
      else n_pass++;
      reset = 1'b1;
      paso();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_total++;
         if ({onda_cuadrada, flanco_pos, config_aplicada, pendiente} !== 4'b0000)
            $display("FAIL reset_marcha k=%0d got %b%b%b%b want 0000",
                     k, onda_cuadrada, flanco_pos, config_aplicada, pendiente);
         else n_pass++;
         paso();
      end
   endtask

   initial begin
      test_reset();
      test_basico();
      test_doble_buffer();
      test_invalida();
      test_clamps();
      test_habilitar();
      test_reset_en_marcha();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
